// File: rtl/map_llr_unit.sv
// map_llr_unit: 3-stage max-log-MAP LLR stage for the 8-state LTE turbo trellis (g0=13, g1=15).
// Define LLR_EXTRINSIC_EN to emit llr = sat(d - lc_sys - la); the default build emits llr = sat(d).

module map_llr_path #(
  parameter int N = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] g,
  input  logic [N-1:0] b,
  output logic [N+1:0] m
);
  assign m = {2'b00, a} + {2'b00, g} + {2'b00, b};
endmodule

module map_llr_unit #(
  parameter int N  = 12,
  parameter int LW = 8,
  parameter int K  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [8*N-1:0]  alpha_bus,
  input  logic [8*N-1:0]  beta_bus,
  input  logic [N-1:0]    gam_00,
  input  logic [N-1:0]    gam_01,
  input  logic [N-1:0]    gam_10,
  input  logic [N-1:0]    gam_11,
  input  logic [LW-1:0]   lc_sys,
  input  logic [LW-1:0]   la,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LW-1:0]   llr,
  output logic            hard,
  output logic            out_last,
  output logic            frame_done,
  output logic            frame_err
);
  localparam int STAGES = 3;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic signed [N+3:0] LMAX = (N+4)'((1 << (LW-1)) - 1);
  localparam logic signed [N+3:0] LMIN = ~LMAX;

  logic [1:0]              state;
  logic [KW-1:0]           k;
  logic [STAGES:1]         vld_pipe, lst_pipe;
  logic                    stall, accept, err;
  logic [3:0][N-1:0]       gam;
  logic [1:0][7:0][N+1:0]  m_c, m1;
  logic [1:0][1:0][N+1:0]  m2_c, m2;
  logic [1:0][N+1:0]       mx;
  logic signed [N+2:0]     d;
  logic signed [N+3:0]     x;
  logic [LW-1:0]           llr_c;

  assign stall    = vld_pipe[STAGES] & ~out_ready;
  assign in_ready = rst & ~stall & (state != DRAIN);
  assign accept   = in_valid & in_ready;
  assign gam      = {gam_11, gam_10, gam_01, gam_00};

  // Trellis wiring is fixed at elaboration: parity and next state per (s,u).
  genvar u, s, i;
  generate
    for (u = 0; u < 2; u++) begin : g_u
      for (s = 0; s < 8; s++) begin : g_s
        localparam int F  = (u ^ (s >> 1) ^ s) & 1;
        localparam int P  = (F ^ (s >> 2) ^ s) & 1;
        localparam int NS = F * 4 + (s >> 1);
        map_llr_path #(.N(N)) u_path (
          .a(alpha_bus[s*N +: N]),
          .g(gam[u*2+P]),
          .b(beta_bus[NS*N +: N]),
          .m(m_c[u][s])
        );
      end
      logic [3:0][N+1:0] l1;
      for (i = 0; i < 4; i++) begin : g_l1
        assign l1[i] = (m1[u][2*i] > m1[u][2*i+1]) ? m1[u][2*i] : m1[u][2*i+1];
      end
      for (i = 0; i < 2; i++) begin : g_l2
        assign m2_c[u][i] = (l1[2*i] > l1[2*i+1]) ? l1[2*i] : l1[2*i+1];
      end
      assign mx[u] = (m2[u][0] > m2[u][1]) ? m2[u][0] : m2[u][1];
    end
  endgenerate

  assign d = $signed({1'b0, mx[1]}) - $signed({1'b0, mx[0]});

`ifdef LLR_EXTRINSIC_EN
  logic [LW-1:0] lc1, la1, lc2, la2;
  always_ff @(posedge clk)
    if (!stall) begin
      lc1 <= lc_sys;
      la1 <= la;
      lc2 <= lc1;
      la2 <= la1;
    end
  assign x = {d[N+2], d} - {{(N+4-LW){lc2[LW-1]}}, lc2} - {{(N+4-LW){la2[LW-1]}}, la2};
`else
  logic unused_side;
  assign unused_side = ^{lc_sys, la};
  assign x = {d[N+2], d};
`endif

  assign llr_c = (x > LMAX) ? LMAX[LW-1:0] : (x < LMIN) ? LMIN[LW-1:0] : x[LW-1:0];

  always_ff @(posedge clk)
    if (!stall) begin
      m1 <= m_c;
      m2 <= m2_c;
    end

  always_ff @(posedge clk)
    if (!rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      llr      <= '0;
      hard     <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      lst_pipe <= {lst_pipe[STAGES-1:1], accept & in_last};
      llr      <= llr_c;
      hard     <= (d > 0);
    end

  // A frame must end exactly on step K-1; anything else latches an error.
  always_ff @(posedge clk)
    if (!rst) begin
      k   <= '0;
      err <= 1'b0;
    end else if (accept) begin
      k <= (in_last || k == KW'(K-1)) ? '0 : k + 1'b1;
      if (in_last != (k == KW'(K-1))) err <= 1'b1;
    end

  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state <= in_last ? DRAIN : RUN;
        RUN:     if (accept && in_last) state <= DRAIN;
        DRAIN:   if (vld_pipe[STAGES] && out_ready && lst_pipe[STAGES]) state <= DONE;
        DONE:    state <= accept ? (in_last ? DRAIN : RUN) : IDLE;
        default: state <= IDLE;
      endcase
    end

  assign out_valid  = vld_pipe[STAGES];
  assign out_last   = lst_pipe[STAGES];
  assign frame_done = (state == DONE);
  assign frame_err  = err;
endmodule

// File: tb/tb_map_llr_unit.sv
// Scoreboard bench for map_llr_unit: randomized steps against a max-log-MAP reference model.
module tb_map_llr_unit;
  localparam int N = 12, LW = 8, K = 8;

  logic           clk = 1'b0, rst = 1'b0;
  logic           in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic           in_ready, out_valid, hard, out_last, frame_done, frame_err;
  logic [8*N-1:0] alpha_bus = '0, beta_bus = '0;
  logic [N-1:0]   gam_00 = '0, gam_01 = '0, gam_10 = '0, gam_11 = '0;
  logic [LW-1:0]  lc_sys = '0, la = '0, llr;

  map_llr_unit #(.N(N), .LW(LW), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .alpha_bus(alpha_bus), .beta_bus(beta_bus),
    .gam_00(gam_00), .gam_01(gam_01), .gam_10(gam_10), .gam_11(gam_11),
    .lc_sys(lc_sys), .la(la), .out_valid(out_valid), .out_ready(out_ready),
    .llr(llr), .hard(hard), .out_last(out_last), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { int llr; int hard; int last; } exp_t;
  exp_t sb[$];
  int   passed = 0, total = 0, out_cnt = 0, fd_cnt = 0, bp_mode = 0;
  bit   hold = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: for each u take the best path metric over all 8 states, then d = M1 - M0.
  function automatic exp_t model(input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                                 input logic [N-1:0] g00, input logic [N-1:0] g01,
                                 input logic [N-1:0] g10, input logic [N-1:0] g11,
                                 input logic [LW-1:0] lc, input logic [LW-1:0] lav, input bit last);
    int g[4], best[2], dd, xx, lim;
    exp_t e;
    g[0] = int'(g00); g[1] = int'(g01); g[2] = int'(g10); g[3] = int'(g11);
    best[0] = -1; best[1] = -1;
    for (int u = 0; u < 2; u++)
      for (int s = 0; s < 8; s++) begin
        int f, p, ns, m;
        f  = u ^ ((s >> 1) & 1) ^ (s & 1);
        p  = f ^ ((s >> 2) & 1) ^ (s & 1);
        ns = f * 4 + (s >> 1);
        m  = int'(a[s*N +: N]) + g[u*2+p] + int'(b[ns*N +: N]);
        if (m > best[u]) best[u] = m;
      end
    dd = best[1] - best[0];
    xx = dd;
`ifdef LLR_EXTRINSIC_EN
    xx = dd - int'($signed(lc)) - int'($signed(lav));
`endif
    lim = (1 << (LW-1));
    e.llr  = (xx > lim - 1) ? lim - 1 : (xx < -lim) ? -lim : xx;
    e.hard = (dd > 0) ? 1 : 0;
    e.last = last ? 1 : 0;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (hold || bp_mode == 1) out_ready = 1'b0;
    else if (bp_mode == 2)    out_ready = ($urandom_range(0, 3) != 0);
    else                      out_ready = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (frame_done) fd_cnt++;
    if (rst && out_valid && out_ready) begin
      out_cnt++;
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("llr", int'($signed(llr)), e.llr);
        chk("hard", int'(hard), e.hard);
        chk("out_last", int'(out_last), e.last);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                      input logic [N-1:0] g00, input logic [N-1:0] g01,
                      input logic [N-1:0] g10, input logic [N-1:0] g11,
                      input logic [LW-1:0] lc, input logic [LW-1:0] lav, input bit last);
    bit ok = 1'b0;
    alpha_bus = a; beta_bus = b;
    gam_00 = g00; gam_01 = g01; gam_10 = g10; gam_11 = g11;
    lc_sys = lc; la = lav; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(model(a, b, g00, g01, g10, g11, lc, lav, last));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  function automatic logic [N-1:0] rnd(input bit big);
    return big ? N'($urandom_range(0, (1 << N) - 1)) : N'($urandom_range(0, 60));
  endfunction

  task automatic send_rand(input bit last);
    logic [8*N-1:0] a, b;
    bit big;
    big = ($urandom_range(0, 2) == 0);
    for (int s = 0; s < 8; s++) begin
      a[s*N +: N] = rnd(big);
      b[s*N +: N] = rnd(big);
    end
    send(a, b, rnd(big), rnd(big), rnd(big), rnd(big),
         LW'($urandom_range(0, 255)), LW'($urandom_range(0, 255)), last);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain_timeout", (n < 400) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, fd0, base, vcnt, rdy;
    logic [LW-1:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_llr", int'(llr), 0);
    chk("rst_hard", int'(hard), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // d=+5 with latency check
    send('0, '0, 12'd0, 12'd0, 12'd5, 12'd5, 8'd2, 8'd1, 1'b0);
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", n + 1, 3);
`ifdef LLR_EXTRINSIC_EN
    chk("llr_d5", int'($signed(llr)), 2);
`else
    chk("llr_d5", int'($signed(llr)), 5);
`endif
    chk("hard_d5", int'(hard), 1);
    @(posedge clk); #1;

    // Saturation both ways, then d=+1
    send('0, '0, 12'd4095, 12'd4095, 12'd0, 12'd0, 8'd0, 8'd0, 1'b0);
    send('0, '0, 12'd0, 12'd0, 12'd4095, 12'd4095, 8'd0, 8'd0, 1'b0);
    send('0, '0, 12'd0, 12'd0, 12'd1, 12'd1, 8'd3, 8'd0, 1'b0);
    // in_last on step 5 of 8
    send_rand(1'b1);
    @(negedge clk);
    chk("frame_err_set", int'(frame_err), 1);
    @(posedge clk); #1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("frame_err_sticky", int'(frame_err), 1);
    chk("frame_done_short", fd_cnt, 1);

    // Mid-frame reset with outputs blocked
    bp_mode = 1;
    repeat (3) send_rand(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_llr", int'(llr), 0);
    chk("mrst_hard", int'(hard), 0);
    chk("mrst_out_last", int'(out_last), 0);
    chk("mrst_frame_err", int'(frame_err), 0);
    chk("mrst_frame_done", int'(frame_done), 0);
    chk("mrst_in_ready", int'(in_ready), 0);
    bp_mode = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rel_in_ready", int'(in_ready), 1);
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("mrst_discarded", vcnt, 0);
    @(posedge clk); #1;

    // Clean back-to-back frame of K steps
    base = out_cnt;
    fd0  = fd_cnt;
    for (int i = 0; i < K; i++) send_rand(i == K-1);
    vcnt = 0; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
      if (in_ready) rdy++;
      if (i == 2) chk("frame_out_last", int'(out_last), 1);
    end
    chk("frame_tail_valid", vcnt, 3);
    chk("drain_in_ready", rdy, 0);
    @(negedge clk);
    chk("frame_done_pulse", int'(frame_done), 1);
    @(negedge clk);
    chk("frame_done_once", int'(frame_done), 0);
    chk("frame_out_count", out_cnt - base, K);
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("frame_err_clean", int'(frame_err), 0);
    @(posedge clk); #1;

    // Four-cycle output stall mid-stream
    fork
      for (int i = 0; i < K; i++) send_rand(i == K-1);
      begin
        vcnt = 0;
        for (n = 0; n < 100 && vcnt < 2; n++) begin
          @(negedge clk);
          if (out_valid) vcnt++;
        end
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_in_ready", int'(in_ready), 0);
          if (i == 0) held = llr;
          else chk("stall_llr_stable", int'(llr), int'(held));
        end
        hold = 1'b0;
      end
    join
    drain();

    // Random frames under random backpressure
    bp_mode = 2;
    fd0 = fd_cnt;
    for (int f = 0; f < 5; f++)
      for (int i = 0; i < K; i++) send_rand(i == K-1);
    drain();
    bp_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rand_frame_done_count", fd_cnt - fd0, 5);
    chk("scoreboard_empty", sb.size(), 0);
    chk("frame_err_final", int'(frame_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
